// File: rtl/spart_rx_param.sv
// SPART receive channel: rxd synchroniser, 16x oversampling baud tick, start/data/parity/stop
// FSM with 3-sample majority vote, and a first-word-fall-through RX FIFO with sticky errors.
module spart_rx_param #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int DIV_W      = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [DIV_W-1:0]              divisor,
  input  logic [1:0]                    parity_mode,
  input  logic                          rxd,
  input  logic                          rd_en,
  output logic [DATA_W-1:0]             rd_data,
  output logic                          rda,
  output logic [$clog2(FIFO_DEPTH):0]   rx_count,
  output logic                          frame_err,
  output logic                          parity_err,
  output logic                          overrun_err,
  input  logic                          err_clr
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int BW = $clog2(DATA_W);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;

  state_e              state_q, state_d;
  logic                sync1_q, sync2_q, prev_q;
  logic [DIV_W-1:0]    tcnt_q, tcnt_d;
  logic [3:0]          os_q, os_d;
  logic [1:0]          samp_q, samp_d;
  logic [BW-1:0]       idx_q, idx_d;
  logic [DATA_W-1:0]   shreg_q, shreg_d;
  logic                wr_q, wr_d;
  logic                frame_err_q, parity_err_q, overrun_err_q;
  logic                fr_set, par_set, ovr_set;
  logic                start_edge, tick, at_res, at_end, vbit, par_bad;

  logic [DATA_W-1:0]   mem [FIFO_DEPTH];
  logic [PW-1:0]       wp_q, rp_q, rp_nxt;
  logic [CW-1:0]       cnt_q;
  logic [DATA_W-1:0]   rd_data_q;
  logic                do_rd, do_wr, full;

  assign start_edge = (state_q == IDLE) && prev_q && !sync2_q;
  assign tick       = (state_q != IDLE) && (tcnt_q == '0);
  assign at_res     = tick && (os_q == 4'd9);
  assign at_end     = tick && (os_q == 4'd15);
  // Samples at os_cnt 7 and 8 are held; the third vote is the live os_cnt 9 sample.
  assign vbit       = (samp_q[0] & samp_q[1]) | (samp_q[0] & sync2_q) | (samp_q[1] & sync2_q);
  assign par_bad    = ((^shreg_q) ^ vbit) != (parity_mode == 2'b10);

  always_comb begin
    state_d = state_q;
    tcnt_d  = tcnt_q;
    os_d    = os_q;
    samp_d  = samp_q;
    idx_d   = idx_q;
    shreg_d = shreg_q;
    wr_d    = 1'b0;
    fr_set  = 1'b0;
    par_set = 1'b0;
    if (start_edge) begin
      tcnt_d = divisor;
      os_d   = 4'd0;
    end else if (state_q != IDLE) begin
      tcnt_d = tick ? divisor : tcnt_q - 1'b1;
    end
    if (tick) begin
      os_d = os_q + 4'd1;
      if (os_q == 4'd7) samp_d[0] = sync2_q;
      if (os_q == 4'd8) samp_d[1] = sync2_q;
    end
    case (state_q)
      IDLE:   if (start_edge) state_d = START;
      START: begin
        if (at_res && vbit) state_d = IDLE;
        else if (at_end) begin
          state_d = DATA;
          idx_d   = '0;
        end
      end
      DATA: begin
        if (at_res) shreg_d = {vbit, shreg_q[DATA_W-1:1]};
        if (at_end) begin
          if (idx_q == BW'(DATA_W-1))
            state_d = (parity_mode == 2'b01 || parity_mode == 2'b10) ? PARITY : STOP;
          else
            idx_d = idx_q + 1'b1;
        end
      end
      PARITY: begin
        if (at_res && par_bad) par_set = 1'b1;
        if (at_end) state_d = STOP;
      end
      STOP: begin
        if (at_res) begin
          state_d = IDLE;
          wr_d    = vbit;
          fr_set  = !vbit;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q       <= 1'b1;
      sync2_q       <= 1'b1;
      prev_q        <= 1'b1;
      state_q       <= IDLE;
      tcnt_q        <= '0;
      os_q          <= '0;
      samp_q        <= '0;
      idx_q         <= '0;
      shreg_q       <= '0;
      wr_q          <= 1'b0;
      frame_err_q   <= 1'b0;
      parity_err_q  <= 1'b0;
      overrun_err_q <= 1'b0;
    end else begin
      sync1_q       <= rxd;
      sync2_q       <= sync1_q;
      prev_q        <= sync2_q;
      state_q       <= state_d;
      tcnt_q        <= tcnt_d;
      os_q          <= os_d;
      samp_q        <= samp_d;
      idx_q         <= idx_d;
      shreg_q       <= shreg_d;
      wr_q          <= wr_d;
      frame_err_q   <= fr_set  | (frame_err_q   & !err_clr);
      parity_err_q  <= par_set | (parity_err_q  & !err_clr);
      overrun_err_q <= ovr_set | (overrun_err_q & !err_clr);
    end
  end

  // FIFO: shreg_q stays stable while the FSM idles, so it is the write data for wr_q.
  assign full    = (cnt_q == CW'(FIFO_DEPTH));
  assign do_rd   = rd_en && (cnt_q != '0);
  assign do_wr   = wr_q && (!full || do_rd);
  assign ovr_set = wr_q && full && !do_rd;
  assign rp_nxt  = rp_q + PW'(1);

  always_ff @(posedge clk) begin
    if (do_wr) mem[wp_q] <= shreg_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp_q      <= '0;
      rp_q      <= '0;
      cnt_q     <= '0;
      rd_data_q <= '0;
    end else begin
      if (do_wr) wp_q <= wp_q + PW'(1);
      if (do_rd) rp_q <= rp_nxt;
      case ({do_wr, do_rd})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
      if (do_rd) begin
        if (cnt_q > CW'(1)) rd_data_q <= mem[rp_nxt];
        else if (do_wr)     rd_data_q <= shreg_q;
      end else if (do_wr && cnt_q == '0) begin
        rd_data_q <= shreg_q;
      end
    end
  end

  assign rd_data     = rd_data_q;
  assign rda         = (cnt_q != '0);
  assign rx_count    = cnt_q;
  assign frame_err   = frame_err_q;
  assign parity_err  = parity_err_q;
  assign overrun_err = overrun_err_q;
endmodule

// File: tb/tb_spart_rx_param.sv
// Directed bench for spart_rx_param: stimulus pushes expected bytes into a queue, a consumer
// process pops the FIFO and compares each presented word; flag checks run inline.
module tb_spart_rx_param;
  localparam int DATA_W = 8, FIFO_DEPTH = 4, DIV_W = 16;
  localparam int BIT_CLK = 64;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [DIV_W-1:0]  divisor = 16'd3;
  logic [1:0]        parity_mode = 2'b00;
  logic              rxd = 1'b1;
  logic              rd_en = 1'b0;
  logic [DATA_W-1:0] rd_data;
  logic              rda;
  logic [$clog2(FIFO_DEPTH):0] rx_count;
  logic              frame_err, parity_err, overrun_err;
  logic              err_clr = 1'b0;

  int          n_cmp = 0, n_err = 0;
  logic [7:0]  exp_q[$];
  bit          want_rd = 0;

  spart_rx_param #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH), .DIV_W(DIV_W)) dut (
    .clk(clk), .rst_n(rst_n), .divisor(divisor), .parity_mode(parity_mode), .rxd(rxd),
    .rd_en(rd_en), .rd_data(rd_data), .rda(rda), .rx_count(rx_count), .frame_err(frame_err),
    .parity_err(parity_err), .overrun_err(overrun_err), .err_clr(err_clr));

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Consumer/monitor: pops whenever enabled and data is presented.
  initial begin
    forever begin
      @(negedge clk);
      if (want_rd && rda) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL pop_unexpected: got %0h want none", rd_data);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          if (rd_data !== e) begin
            n_err++;
            $display("FAIL pop_data: got %0h want %0h", rd_data, e);
          end
        end
        rd_en = 1'b1;
      end else begin
        rd_en = 1'b0;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic drive_bit(input logic b);
    rxd = b;
    repeat (BIT_CLK) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input bit use_par, input logic pbit,
                            input logic stop, input int gap);
    drive_bit(1'b0);
    for (int i = 0; i < DATA_W; i++) drive_bit(d[i]);
    if (use_par) drive_bit(pbit);
    drive_bit(stop);
    rxd = 1'b1;
    repeat (gap) @(negedge clk);
  endtask

  task automatic wait_drain(input string nm);
    int n = 0;
    while (rda && n < 200) begin
      @(negedge clk);
      n++;
    end
    check(nm, rda, 1'b0);
  endtask

  initial begin
    int lat;
    // Reset state
    repeat (3) @(negedge clk);
    check("reset_rda", rda, 0);
    check("reset_count", rx_count, 0);
    check("reset_rd_data", rd_data, 0);
    check("reset_flags", {frame_err, parity_err, overrun_err}, 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // 0xA5 8N1 with latency measured from the start of the stop bit
    exp_q.push_back(8'hA5);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(1'(8'hA5 >> i));
    rxd = 1'b1;
    lat = 0;
    while (!rda && lat < BIT_CLK) begin
      @(negedge clk);
      lat++;
    end
    check("a5_latency", lat, 44);
    repeat (BIT_CLK - lat + 8) @(negedge clk);
    check("a5_count", rx_count, 1);
    check("a5_flags", {frame_err, parity_err, overrun_err}, 0);
    want_rd = 1;
    wait_drain("a5_drain");

    // Glitch rejection
    rxd = 1'b0;
    repeat (20) @(negedge clk);
    rxd = 1'b1;
    repeat (150) @(negedge clk);
    check("glitch_rda", rda, 0);
    check("glitch_flags", {frame_err, parity_err, overrun_err}, 0);

    // Even parity, wrong parity bit: data still written
    parity_mode = 2'b01;
    want_rd = 0;
    exp_q.push_back(8'h03);
    send_frame(8'h03, 1, 1'b1, 1'b1, 16);
    check("par_err_set", parity_err, 1);
    check("par_frame_ok", frame_err, 0);
    check("par_count", rx_count, 1);
    want_rd = 1;
    wait_drain("par_drain");
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("par_err_clr", parity_err, 0);

    // Odd parity, correct parity bit (0x03 has even ones -> pbit 1)
    parity_mode = 2'b10;
    exp_q.push_back(8'h03);
    send_frame(8'h03, 1, 1'b1, 1'b1, 16);
    check("odd_par_ok", parity_err, 0);
    wait_drain("odd_drain");
    parity_mode = 2'b00;

    // Stop bit low: frame error, nothing written
    send_frame(8'h5A, 0, 1'b0, 1'b0, 16);
    check("frame_err_set", frame_err, 1);
    check("frame_rda", rda, 0);
    check("frame_count", rx_count, 0);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("frame_err_clr", frame_err, 0);

    // Overrun: five back-to-back frames into a four-entry FIFO
    want_rd = 0;
    for (int k = 1; k <= 5; k++) begin
      if (k <= 4) exp_q.push_back(8'(k * 8'h11));
      send_frame(8'(k * 8'h11), 0, 1'b0, 1'b1, 8);
    end
    repeat (10) @(negedge clk);
    check("ovr_flag", overrun_err, 1);
    check("ovr_count", rx_count, 4);
    want_rd = 1;
    wait_drain("ovr_drain");
    check("ovr_queue_empty", exp_q.size(), 0);

    // Reset mid-DATA, then a clean frame
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b1);
    rxd = 1'b0;
    repeat (20) @(negedge clk);
    rst_n = 1'b0;
    rxd = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_mid_rda", rda, 0);
    check("rst_mid_count", rx_count, 0);
    check("rst_mid_rd_data", rd_data, 0);
    check("rst_mid_flags", {frame_err, parity_err, overrun_err}, 0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 0, 1'b0, 1'b1, 16);
    wait_drain("rst_drain");
    check("final_queue_empty", exp_q.size(), 0);
    check("final_flags", {frame_err, parity_err, overrun_err}, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
